// File: rtl/adder6_arbiter.sv
// rtl/adder6_arbiter.sv - round-robin arbiter sharing one 8-bit prefix adder among requesters
module adder6 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] sum
);
    logic [7:0] g0, p0, g1, p1, g2, p2, g3;

    // Kogge-Stone carry tree: after level k, g covers a span of 2^k bits
    assign g0 = a & b;
    assign p0 = a ^ b;
    assign g1 = g0 | (p0 & {g0[6:0], 1'b0});
    assign p1 = p0 & {p0[6:0], 1'b1};
    assign g2 = g1 | (p1 & {g1[5:0], 2'b00});
    assign p2 = p1 & {p1[5:0], 2'b11};
    assign g3 = g2 | (p2 & {g2[3:0], 4'b0000});
    assign sum = p0 ^ {g3[6:0], 1'b0};
endmodule

module adder6_arbiter #(
    parameter int  NUM_REQ = 4,
    parameter int  CNT_W   = 16,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [8*NUM_REQ-1:0] req_a,
    input  logic [8*NUM_REQ-1:0] req_b,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [7:0]           resp_sum,
    output logic [ID_W-1:0]      resp_id,
    input  logic                 clr_cnt,
    output logic [CNT_W-1:0]     grant_cnt
);
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] grant_idx;
    logic            grant_found;
    logic            slot_free;
    logic            transfer;
    logic [7:0]      op_a, op_b, add_sum;
    int              scan_idx;

    assign slot_free = !resp_valid || resp_ready;

    // Scan starting at rr_ptr; the first valid requester found wins
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(scan_idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (rst_n && slot_free && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign transfer = |req_ready;
    assign op_a     = req_a[{grant_idx, 3'b000} +: 8];
    assign op_b     = req_b[{grant_idx, 3'b000} +: 8];

    adder6 u_adder6 (
        .a   (op_a),
        .b   (op_b),
        .sum (add_sum)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resp_valid <= 1'b0;
            resp_sum   <= '0;
            resp_id    <= '0;
            rr_ptr     <= '0;
            grant_cnt  <= '0;
        end else begin
            if (transfer) begin
                resp_valid <= 1'b1;
                resp_sum   <= add_sum;
                resp_id    <= grant_idx;
                rr_ptr     <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end else if (resp_ready) begin
                resp_valid <= 1'b0;
            end

            // Clear takes priority over a same-cycle increment
            if (clr_cnt) begin
                grant_cnt <= '0;
            end else if (transfer && grant_cnt != {CNT_W{1'b1}}) begin
                grant_cnt <= grant_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_adder6_arbiter.sv
// tb/tb_adder6_arbiter.sv - self-checking bench for adder6_arbiter with behavioural model
module tb_adder6_arbiter;
    localparam int N    = 4;
    localparam int ID_W = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [8*N-1:0] req_a;
    logic [8*N-1:0] req_b;
    logic           resp_valid;
    logic           resp_ready;
    logic [7:0]     resp_sum;
    logic [ID_W-1:0] resp_id;
    logic           clr_cnt;
    logic [15:0]    grant_cnt;

    int checks = 0;
    int errors = 0;

    adder6_arbiter #(.NUM_REQ(N), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_sum   (resp_sum),
        .resp_id    (resp_id),
        .clr_cnt    (clr_cnt),
        .grant_cnt  (grant_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
        req_a[8*i +: 8] = a;
        req_b[8*i +: 8] = b;
    endtask

    // Winner is the valid requester at the smallest cyclic distance from the pointer
    function automatic int pick(input logic [N-1:0] v, input int ptr);
        int best;
        int bd;
        int d;
        best = -1;
        bd   = N;
        for (int i = 0; i < N; i++) begin
            d = (i - ptr + N) % N;
            if (v[i] && d < bd) begin
                bd   = d;
                best = i;
            end
        end
        return best;
    endfunction

    bit          model_ok = 0;
    int          m_ptr;
    bit          m_valid;
    int          m_sum;
    int          m_id;
    int          m_cnt;

    always @(negedge clk) begin
        int          g;
        logic [N-1:0] exp_ready;
        g = -1;
        exp_ready = '0;
        if (model_ok && rst_n && (!m_valid || resp_ready)) begin
            g = pick(req_valid, m_ptr);
            if (g >= 0) exp_ready[g] = 1'b1;
        end
        if (model_ok) begin
            check("m_req_ready", 32'(req_ready), 32'(exp_ready));
            check("m_resp_valid", 32'(resp_valid), 32'(m_valid));
            check("m_resp_sum", 32'(resp_sum), m_sum);
            check("m_resp_id", 32'(resp_id), m_id);
            check("m_grant_cnt", 32'(grant_cnt), m_cnt);
        end
        if (!rst_n) begin
            model_ok = 1;
            m_ptr = 0; m_valid = 0; m_sum = 0; m_id = 0; m_cnt = 0;
        end else if (model_ok) begin
            if (g >= 0) begin
                m_sum   = (int'(req_a[8*g +: 8]) + int'(req_b[8*g +: 8])) % 256;
                m_id    = g;
                m_valid = 1;
                m_ptr   = (g + 1) % N;
            end else if (resp_ready) begin
                m_valid = 0;
            end
            if (clr_cnt) m_cnt = 0;
            else if (g >= 0 && m_cnt < 65535) m_cnt = m_cnt + 1;
        end
    end

    initial begin
        logic [N-1:0] acc;
        rst_n = 0; req_valid = '1; req_a = '0; req_b = '0; resp_ready = 1; clr_cnt = 0;

        // reset values, request presented during reset is ignored
        next_cycle(); next_cycle();
        sample();
        check("rst_resp_valid", 32'(resp_valid), 0);
        check("rst_resp_sum", 32'(resp_sum), 0);
        check("rst_resp_id", 32'(resp_id), 0);
        check("rst_grant_cnt", 32'(grant_cnt), 0);
        check("rst_req_ready", 32'(req_ready), 0);

        // single request then wrap-around sums
        next_cycle(); rst_n = 1; req_valid = 4'b0001; set_op(0, 8'h3C, 8'h05);
        sample(); check("single_ready", 32'(req_ready), 32'h1);
        next_cycle(); req_valid = 4'b0100; set_op(2, 8'hFF, 8'h02);
        sample();
        check("single_valid", 32'(resp_valid), 1);
        check("single_sum", 32'(resp_sum), 32'h41);
        check("single_id", 32'(resp_id), 0);
        check("single_cnt", 32'(grant_cnt), 1);
        check("wrap2_ready", 32'(req_ready), 32'h4);
        next_cycle(); req_valid = 4'b0010; set_op(1, 8'h80, 8'h80);
        sample();
        check("wrap2_sum", 32'(resp_sum), 32'h01);
        check("wrap2_id", 32'(resp_id), 2);
        check("wrap1_ready", 32'(req_ready), 32'h2);
        next_cycle(); req_valid = 4'b0000;
        sample();
        check("wrap1_sum", 32'(resp_sum), 32'h00);
        check("wrap1_id", 32'(resp_id), 1);
        check("wrap_cnt", 32'(grant_cnt), 3);

        // round-robin from reset with all requesters valid
        next_cycle(); rst_n = 0;
        next_cycle(); rst_n = 1; req_valid = 4'b1111;
        for (int i = 0; i < N; i++) set_op(i, 8'($urandom), 8'($urandom));
        for (int k = 0; k < 6; k++) begin
            sample();
            check("rr_ready", 32'(req_ready), 32'(1 << (k % 4)));
            if (k > 0) check("rr_id", 32'(resp_id), (k - 1) % 4);
            next_cycle();
        end

        // backpressure holds the response and blocks all grants
        rst_n = 0;
        next_cycle(); rst_n = 1; req_valid = 4'b0010; set_op(1, 8'h11, 8'h11); resp_ready = 1;
        sample(); check("bp_first_ready", 32'(req_ready), 32'h2);
        next_cycle(); resp_ready = 0; req_valid = 4'b1111; set_op(2, 8'h30, 8'h07);
        for (int k = 0; k < 3; k++) begin
            sample();
            check("bp_ready", 32'(req_ready), 0);
            check("bp_valid", 32'(resp_valid), 1);
            check("bp_sum", 32'(resp_sum), 32'h22);
            check("bp_id", 32'(resp_id), 1);
            next_cycle();
        end
        resp_ready = 1;
        sample(); check("bp_release_ready", 32'(req_ready), 32'h4);
        next_cycle();
        sample();
        check("bp_new_sum", 32'(resp_sum), 32'h37);
        check("bp_new_id", 32'(resp_id), 2);

        // counter: clear wins over a same-cycle transfer, then saturation
        next_cycle(); rst_n = 0;
        next_cycle(); rst_n = 1; req_valid = 4'b0001; resp_ready = 1;
        repeat (5) next_cycle();
        clr_cnt = 1;
        sample();
        check("cnt_five", 32'(grant_cnt), 5);
        check("cnt_clr_xfer", 32'(req_ready), 32'h1);
        next_cycle(); clr_cnt = 0;
        sample(); check("cnt_cleared", 32'(grant_cnt), 0);
        repeat (65535) next_cycle();
        sample(); check("cnt_max", 32'(grant_cnt), 32'hFFFF);
        repeat (2) next_cycle();
        sample(); check("cnt_sat", 32'(grant_cnt), 32'hFFFF);

        // reset mid-stream drops the pending response
        req_valid = 4'b1111;
        next_cycle();
        sample(); check("mid_pending", 32'(resp_valid), 1);
        next_cycle(); rst_n = 0;
        sample(); check("mid_rst_ready", 32'(req_ready), 0);
        next_cycle();
        sample();
        check("mid_rst_valid", 32'(resp_valid), 0);
        check("mid_rst_ready2", 32'(req_ready), 0);
        next_cycle(); rst_n = 1;
        sample(); check("mid_first_grant", 32'(req_ready), 32'h1);

        // randomized traffic with requester hold-until-accept protocol
        for (int n = 0; n < 4000; n++) begin
            sample();
            acc = req_ready;
            next_cycle();
            rst_n      = ($urandom_range(0, 99) != 0);
            resp_ready = ($urandom_range(0, 9) < 7);
            clr_cnt    = ($urandom_range(0, 49) == 0);
            for (int i = 0; i < N; i++) begin
                if (!(req_valid[i] && !acc[i])) begin
                    req_valid[i] = 1'($urandom_range(0, 1));
                    set_op(i, 8'($urandom), 8'($urandom));
                end
            end
        end

        repeat (2) next_cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/adder6_arbiter.md
Name: adder6_arbiter

Overview:
- Round-robin arbiter that shares one instance of the 8-bit prefix adder `adder6` among NUM_REQ requesters.
- Each requester offers an operand pair with a valid/ready handshake.
- The block grants one requester per cycle, adds its operands, and returns the sum with the requester ID through a registered, back-pressurable response port.
- Sits between user-project client logic and the shared adder datapath in the Caravel user area.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- ID_W, $clog2(NUM_REQ), width of the requester ID; derived, not overridden.
- CNT_W, 16, width of the saturating grant counter.

Ports:
- clk  input  1  single clock; all logic rising-edge.
- rst_n  input  1  reset, synchronous, active-low.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept strobe; one-hot or zero.
- req_a  input  8*NUM_REQ  operand A; requester i uses bits [8i+7:8i].
- req_b  input  8*NUM_REQ  operand B; same packing as req_a.
- resp_valid  output  1  response register holds a result.
- resp_ready  input  1  consumer accepts the response this cycle.
- resp_sum  output  8  (a+b) mod 256 from `adder6`.
- resp_id  output  ID_W  index of the requester that produced resp_sum.
- clr_cnt  input  1  synchronous clear of grant_cnt.
- grant_cnt  output  CNT_W  total accepted requests, saturating.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - resp_valid=0, resp_sum=0, resp_id=0, rr_ptr=0, grant_cnt=0.
  - req_ready is forced to all-zero while rst_n=0.
- slot_free = !resp_valid || resp_ready (combinational).
- Arbitration (combinational):
  - If slot_free and req_valid!=0, g = the first index with req_valid set, scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - req_ready = one-hot(g); otherwise req_ready=0.
  - req_ready depends on req_valid. Requesters must not make req_valid depend on req_ready.
- Transfer: requester i transfers when req_valid[i] && req_ready[i]. At most one transfer per cycle.
- On a transfer, at the next edge:
  - resp_sum <= adder6(req_a[g], req_b[g]).
  - resp_id <= g.
  - resp_valid <= 1.
  - rr_ptr <= (g+1) mod NUM_REQ.
- No transfer and resp_ready=1: resp_valid <= 0; resp_sum and resp_id hold their last values.
- Stall (resp_valid=1 and resp_ready=0):
  - req_ready=0.
  - resp_sum, resp_id and rr_ptr are stable.
  - Requesters must hold their valid and operands.
- Latency and throughput:
  - Request accept to resp_valid is 1 cycle.
  - Full throughput is 1 result/cycle when resp_ready is held at 1 (back-to-back accepts allowed because slot_free=1).
- Arithmetic:
  - 8-bit modulo sum, no carry-out, no carry-in.
  - The adder is combinational; its only register stage is the response register.
- rr_ptr: updates only on a transfer; it never advances on idle cycles.
- Fairness: any requester holding req_valid is granted within NUM_REQ transfers.
- grant_cnt:
  - +1 per transfer, saturating at 2^CNT_W-1.
  - clr_cnt=1 sets it to 0 at the next edge. If a transfer occurs in the same cycle, the clear wins and the result is 0.
- Reset mid-operation: a pending response is dropped (resp_valid=0) and rr_ptr returns to 0. A request presented during reset is not accepted.
- Single-requester case: a lone valid requester is granted every cycle regardless of rr_ptr.

Test Plan:
- Reset then single request:
  - Stimulus: rst_n low 2 cycles; req_valid=0001, req_a[0]=0x3C, req_b[0]=0x05, resp_ready=1.
  - Required: req_ready=0001 in that cycle; next cycle resp_valid=1, resp_sum=0x41, resp_id=0; grant_cnt=1.
- Wrap-around:
  - Stimulus: requester 2, a=0xFF, b=0x02.
  - Required: resp_sum=0x01.
  - Stimulus: requester 1, a=0x80, b=0x80.
  - Required: resp_sum=0x00.
- Round-robin:
  - Stimulus: req_valid=1111 held, resp_ready=1, from reset.
  - Required: resp_id sequence 0,1,2,3,0 on consecutive cycles; each requester granted exactly once per 4 cycles.
- Backpressure:
  - Stimulus: response pending for id 1, sum 0x22; resp_ready=0 for 3 cycles; req_valid=1111.
  - Required: req_ready=0000 throughout; resp_sum=0x22 and resp_id=1 stable.
  - Stimulus: resp_ready=1.
  - Required: that same cycle req_ready=0100 (rr_ptr=2); next cycle the new result appears.
- Counter:
  - Stimulus: 5 transfers, then clr_cnt=1 in a cycle with a transfer.
  - Required: grant_cnt reads 5 before the clear and 0 after.
  - Stimulus: preload by running 65535+2 transfers.
  - Required: grant_cnt saturates at 0xFFFF.
- Reset mid-stream:
  - Stimulus: assert rst_n=0 while resp_valid=1 and req_valid=1111.
  - Required: next cycle resp_valid=0 and req_ready=0. After release, the first grant goes to requester 0.
